output_drain_sequencer: RTL and testbench
=========================================

OUTPUT_DRAIN_SEQUENCER -- requirements
Module: output_drain_sequencer

Interface
REQ-001 SHALL have parameter DW, default 16, meaning result word width.
REQ-002 SHALL have parameter Dimension, default 16, meaning number of output result BRAM banks.
REQ-003 SHALL have parameter ADDR_W, default 4, meaning bank address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port start  input  1  drain request pulse, sampled in S_IDLE only.
REQ-007 SHALL have port num_words  input  ADDR_W+1  addresses to drain, sampled with start.
REQ-008 SHALL have port clear_en  input  1  zero each address after reading, sampled with start.
REQ-009 SHALL have port enb_output_result_control  output  Dimension  port-B read enable, all banks.
REQ-010 SHALL have port addrb  output  ADDR_W  port-B read address.
REQ-011 SHALL have port doutb  input  Dimension*DW  concatenated port-B data, bank 0 in LSBs.
REQ-012 SHALL have port ena_clear  output  Dimension  port-A enable for the clear write.
REQ-013 SHALL have port wea_clear  output  Dimension  port-A write enable for the clear write; data path forces zero while asserted.
REQ-014 SHALL have port addra_clear  output  ADDR_W  port-A clear address.
REQ-015 SHALL have port m_data  output  DW  streamed result word.
REQ-016 SHALL have port m_valid  output  1  m_data valid.
REQ-017 SHALL have port m_ready  input  1  downstream accept.
REQ-018 SHALL have port busy  output  1  high in every state except S_IDLE.
REQ-019 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-020 SHALL implement states S_IDLE, S_READ, S_WAIT_DATA, S_LATCH, S_STREAM, S_NEXT, S_DONE.
REQ-021 S_IDLE: start=1 with num_words>0 -> S_READ, addr counter cleared to 0, num_words/clear_en latched; start with num_words=0 -> S_DONE with no BRAM access.
REQ-022 S_READ and S_WAIT_DATA SHALL drive enb_output_result_control all-ones and addrb = addr counter; always S_READ -> S_WAIT_DATA -> S_LATCH (2-cycle BRAM read latency).
REQ-023 S_LATCH SHALL capture doutb into a Dimension x DW buffer, reset lane index to 0, and, if latched clear_en=1, drive ena_clear and wea_clear all-ones with addra_clear = addr counter for exactly this cycle; next S_STREAM.
REQ-024 S_STREAM SHALL present buffer lane[lane index] on registered m_data with m_valid=1; m_data and m_valid SHALL hold stable until m_valid&&m_ready.
REQ-025 On a handshake in S_STREAM, lane index SHALL increment; on handshake of lane Dimension-1, m_valid SHALL drop next cycle and state -> S_NEXT.
REQ-026 S_NEXT SHALL increment addr counter; if new count equals latched num_words -> S_DONE, else -> S_READ.
REQ-027 S_DONE SHALL assert done for one cycle, then -> S_IDLE.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 Latency: start sampled in cycle T -> first m_valid in cycle T+4 with m_ready held high.
REQ-030 Throughput with m_ready=1: one word per cycle within an address; 4 overhead cycles per address (S_READ, S_WAIT_DATA, S_LATCH, S_NEXT).
REQ-031 Words SHALL be emitted address-ascending, bank-ascending; no word dropped or duplicated under any m_ready pattern.
REQ-032 enb, ena_clear, wea_clear SHALL be all-zero in every state not listed above.

Reset
REQ-033 rst=0 at a clock edge SHALL force S_IDLE, counters and buffer to 0, and every output to 0, including mid-stream; an unaccepted m_valid is abandoned.
REQ-034 No clear write SHALL be issued in the cycle reset is applied.

Structure
REQ-035 State encodings and DW/Dimension/ADDR_W defaults SHALL reside in a shared package used with the accumulating output microsequencer.
REQ-036 The lane buffer and mux SHALL be one sub-module, output_lane_buffer (parallel load, indexed read).

Verification
REQ-037 num_words=2, banks preloaded bank*16+addr, m_ready=1 -> 32 words 0x00,0x10..0xF0,0x01..0xF1; first m_valid at start+4; done at start+41.
REQ-038 num_words=1, m_ready toggled 1/0 each cycle -> 16 words in order, m_data stable while m_valid&&!m_ready.
REQ-039 clear_en=1, num_words=3 -> exactly 3 clear writes, addresses 0,1,2, each in S_LATCH; rerun reads all zeros.
REQ-040 num_words=0 -> done one cycle after start; enb never asserted; m_valid never asserted.
REQ-041 rst=0 during address 1 lane 5 -> all outputs 0 next cycle; fresh start drains from address 0.
REQ-042 start pulsed during S_STREAM -> ignored; word count and done count unchanged.

Source files
------------

// File: rtl/output_drain_sequencer_pkg.sv
// Shared definitions for the output drain / accumulate microsequencers:
// default geometry and drain FSM state encodings.
package output_drain_sequencer_pkg;
  localparam int DW_DEF     = 16;
  localparam int DIM_DEF    = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_LATCH     = 3'd3,
    S_STREAM    = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } drain_state_e;
endpackage

// File: rtl/output_lane_buffer.sv
// Holds one BRAM row (all banks) and muxes out a single lane by index.
module output_lane_buffer #(
  parameter int DW        = 16,
  parameter int Dimension = 16,
  parameter int LW        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [Dimension*DW-1:0] din,
  input  logic [LW-1:0]           sel,
  output logic [DW-1:0]           dout
);
  logic [Dimension-1:0][DW-1:0] lanes;

  always_ff @(posedge clk) begin
    if (!rst)      lanes <= '0;
    else if (load) lanes <= din;
  end

  assign dout = lanes[sel];
endmodule

// File: rtl/output_drain_sequencer.sv
// Drains result BRAM rows address by address, streaming each bank's word
// over a valid/ready port and optionally zeroing each row after it is read.
module output_drain_sequencer #(
  parameter int DW        = output_drain_sequencer_pkg::DW_DEF,
  parameter int Dimension = output_drain_sequencer_pkg::DIM_DEF,
  parameter int ADDR_W    = output_drain_sequencer_pkg::ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W:0]         num_words,
  input  logic                    clear_en,
  output logic [Dimension-1:0]    enb_output_result_control,
  output logic [ADDR_W-1:0]       addrb,
  input  logic [Dimension*DW-1:0] doutb,
  output logic [Dimension-1:0]    ena_clear,
  output logic [Dimension-1:0]    wea_clear,
  output logic [ADDR_W-1:0]       addra_clear,
  output logic [DW-1:0]           m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    done
);
  import output_drain_sequencer_pkg::*;

  localparam int LW = (Dimension > 1) ? $clog2(Dimension) : 1;
  localparam logic [LW-1:0]   LANE_LAST = LW'(Dimension - 1);
  localparam logic [LW-1:0]   LANE_ONE  = LW'(1);
  localparam logic [ADDR_W:0] ADDR_ONE  = (ADDR_W+1)'(1);

  drain_state_e    state;
  logic [ADDR_W:0] addr, addr_nxt, nwords;
  logic            clr, enb_q, ena_q;
  logic [LW-1:0]   lane, lane_nxt;
  logic [DW-1:0]   buf_dout;

  assign addr_nxt = addr + ADDR_ONE;
  assign lane_nxt = lane + LANE_ONE;

  // Buffer is read one lane ahead so m_data can be reloaded on the handshake edge.
  output_lane_buffer #(.DW(DW), .Dimension(Dimension), .LW(LW)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .load (state == S_LATCH),
    .din  (doutb),
    .sel  (lane_nxt),
    .dout (buf_dout)
  );

  assign enb_output_result_control = {Dimension{enb_q}};
  // Gated with reset so no clear write can land in the cycle reset is applied.
  assign ena_clear = {Dimension{ena_q & rst}};
  assign wea_clear = {Dimension{ena_q & rst}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      nwords      <= '0;
      clr         <= 1'b0;
      lane        <= '0;
      enb_q       <= 1'b0;
      addrb       <= '0;
      ena_q       <= 1'b0;
      addra_clear <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done  <= 1'b0;
      ena_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            nwords <= num_words;
            clr    <= clear_en;
            addr   <= '0;
            busy   <= 1'b1;
            if (num_words != '0) begin
              state <= S_READ;
              enb_q <= 1'b1;
              addrb <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_READ: state <= S_WAIT_DATA;
        S_WAIT_DATA: begin
          state       <= S_LATCH;
          enb_q       <= 1'b0;
          ena_q       <= clr;
          addra_clear <= addr[ADDR_W-1:0];
        end
        S_LATCH: begin
          // Lane 0 comes straight off the BRAM bus; the buffer is loading this edge.
          state   <= S_STREAM;
          lane    <= '0;
          m_data  <= doutb[DW-1:0];
          m_valid <= 1'b1;
        end
        S_STREAM: begin
          if (m_ready) begin
            lane <= lane_nxt;
            if (lane == LANE_LAST) begin
              m_valid <= 1'b0;
              state   <= S_NEXT;
            end else begin
              m_data <= buf_dout;
            end
          end
        end
        S_NEXT: begin
          addr <= addr_nxt;
          if (addr_nxt == nwords) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_READ;
            enb_q <= 1'b1;
            addrb <= addr_nxt[ADDR_W-1:0];
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_drain_sequencer.sv
// Directed bench for output_drain_sequencer with a 2-cycle-latency BRAM model.
module tb_output_drain_sequencer;
  localparam int DW  = 16;
  localparam int DIM = 16;
  localparam int AW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic clear_en = 1'b0;
  logic m_ready = 1'b0;
  logic [AW:0] num_words = '0;
  logic [DIM-1:0] enb, ena_clear, wea_clear;
  logic [AW-1:0] addrb, addra_clear;
  logic [DIM*DW-1:0] doutb, rd1;
  logic [DW-1:0] m_data;
  logic m_valid, busy, done;

  logic [DW-1:0] mem [DIM][16];
  logic preload = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [DW-1:0] words[$];
  int vrise[$], dq[$], clr_addr[$], clr_cyc[$];
  int enb_cnt = 0;
  int stab_err = 0;
  logic prev_stall = 1'b0, prev_mv = 1'b0;
  logic [DW-1:0] prev_data = '0;

  output_drain_sequencer #(.DW(DW), .Dimension(DIM), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .clear_en(clear_en),
    .enb_output_result_control(enb), .addrb(addrb), .doutb(doutb),
    .ena_clear(ena_clear), .wea_clear(wea_clear), .addra_clear(addra_clear),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: port B 2-cycle read, port A clear write; preload pattern bank*16+addr.
  always @(posedge clk) begin
    for (int b = 0; b < DIM; b++) begin
      if (preload) begin
        for (int a = 0; a < 16; a++) mem[b][a] <= DW'(b * 16 + a);
      end else if (ena_clear[b] && wea_clear[b]) begin
        mem[b][addra_clear] <= '0;
      end
      if (enb[b]) rd1[b*DW +: DW] <= mem[b][addrb];
    end
    doutb <= rd1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
      prev_mv    <= 1'b0;
    end else begin
      if (m_valid && m_ready) words.push_back(m_data);
      if (m_valid && !prev_mv) vrise.push_back(cyc);
      if (done) dq.push_back(cyc);
      if (enb != '0) enb_cnt <= enb_cnt + 1;
      if ((ena_clear & wea_clear) != '0) begin
        clr_addr.push_back(int'(addra_clear));
        clr_cyc.push_back(cyc);
      end
      if (prev_stall && (!m_valid || m_data !== prev_data)) stab_err <= stab_err + 1;
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_mv    <= m_valid;
    end
  end

  task automatic do_preload();
    @(posedge clk); #1; preload = 1'b1;
    @(posedge clk); #1; preload = 1'b0;
  endtask

  task automatic do_start(input int nw, input logic ce, output int sc);
    @(posedge clk); #1;
    start = 1'b1; num_words = (AW+1)'(nw); clear_en = ce; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0; clear_en = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n = 0;
    while (dq.size() == base && n < budget) begin @(posedge clk); n++; end
    checks++;
    if (dq.size() == base) begin
      failures++;
      $display("FAIL %s_done_timeout: no done within %0d cycles, required one", name, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({m_valid, busy, done} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {m_valid, busy, done}); end
    checks++; if (enb !== '0) begin failures++; $display("FAIL reset_enb: got %h want 0", enb); end
    checks++; if ((ena_clear | wea_clear) !== '0) begin failures++; $display("FAIL reset_clear: got %h want 0", ena_clear | wea_clear); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    checks++; if ({addrb, addra_clear} !== '0) begin failures++; $display("FAIL reset_addr: got %h want 0", {addrb, addra_clear}); end
    rst = 1'b1;
  endtask

  task automatic test_drain_two();
    int sc, wb, vb, db, cb;
    do_preload();
    m_ready = 1'b1;
    wb = words.size(); vb = vrise.size(); db = dq.size(); cb = clr_addr.size();
    do_start(2, 1'b0, sc);
    wait_done(db, 100, "drain_two");
    checks++; if (words.size() - wb != 32) begin failures++; $display("FAIL drain_two_count: got %0d want 32", words.size() - wb); end
    if (words.size() >= wb + 32)
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (words[wb+i] !== DW'((i % 16) * 16 + i / 16)) begin
          failures++; $display("FAIL drain_two_word%0d: got %h want %h", i, words[wb+i], DW'((i % 16) * 16 + i / 16));
        end
      end
    checks++; if (vrise.size() <= vb || vrise[vb] - sc != 4) begin failures++; $display("FAIL drain_two_latency: got %0d want 4", vrise.size() > vb ? vrise[vb] - sc : -1); end
    checks++; if (dq.size() <= db || dq[db] - sc != 41) begin failures++; $display("FAIL drain_two_done_cycle: got %0d want 41", dq.size() > db ? dq[db] - sc : -1); end
    checks++; if (clr_addr.size() != cb) begin failures++; $display("FAIL drain_two_no_clear: got %0d clears want 0", clr_addr.size() - cb); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_two_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_toggle();
    int sc, wb, db, sb, n;
    do_preload();
    m_ready = 1'b1;
    wb = words.size(); db = dq.size(); sb = stab_err;
    do_start(1, 1'b0, sc);
    n = 0;
    while (dq.size() == db && n < 200) begin m_ready = ~m_ready; @(posedge clk); #1; n++; end
    m_ready = 1'b1;
    checks++; if (dq.size() == db) begin failures++; $display("FAIL toggle_done_timeout: no done in 200 cycles, required one"); end
    checks++; if (words.size() - wb != 16) begin failures++; $display("FAIL toggle_count: got %0d want 16", words.size() - wb); end
    if (words.size() >= wb + 16)
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (words[wb+i] !== DW'(i * 16)) begin failures++; $display("FAIL toggle_word%0d: got %h want %h", i, words[wb+i], DW'(i * 16)); end
      end
    checks++; if (stab_err != sb) begin failures++; $display("FAIL toggle_stable: got %0d unstable stalls want 0", stab_err - sb); end
  endtask

  task automatic test_clear();
    int sc, wb, db, cb, nz;
    do_preload();
    m_ready = 1'b1;
    wb = words.size(); db = dq.size(); cb = clr_addr.size();
    do_start(3, 1'b1, sc);
    wait_done(db, 150, "clear");
    checks++; if (clr_addr.size() - cb != 3) begin failures++; $display("FAIL clear_count: got %0d want 3", clr_addr.size() - cb); end
    if (clr_addr.size() >= cb + 3)
      for (int i = 0; i < 3; i++) begin
        checks++; if (clr_addr[cb+i] != i) begin failures++; $display("FAIL clear_addr%0d: got %0d want %0d", i, clr_addr[cb+i], i); end
        checks++; if (clr_cyc[cb+i] - sc != 3 + 20 * i) begin failures++; $display("FAIL clear_cycle%0d: got %0d want %0d", i, clr_cyc[cb+i] - sc, 3 + 20 * i); end
      end
    checks++; if (words.size() < wb + 48 || words[wb+17] !== 16'h0011) begin failures++; $display("FAIL clear_preread: got %h want 0011", words.size() >= wb + 48 ? words[wb+17] : 16'hxxxx); end
    checks++; if (dq.size() <= db || dq[db] - sc != 61) begin failures++; $display("FAIL clear_done_cycle: got %0d want 61", dq.size() > db ? dq[db] - sc : -1); end
    wb = words.size(); db = dq.size(); cb = clr_addr.size();
    do_start(3, 1'b0, sc);
    wait_done(db, 150, "clear_rerun");
    checks++; if (words.size() - wb != 48) begin failures++; $display("FAIL clear_rerun_count: got %0d want 48", words.size() - wb); end
    nz = 0;
    for (int i = wb; i < words.size(); i++) if (words[i] !== '0) nz++;
    checks++; if (nz != 0) begin failures++; $display("FAIL clear_rerun_zero: got %0d nonzero words want 0", nz); end
    checks++; if (clr_addr.size() != cb) begin failures++; $display("FAIL clear_rerun_noclear: got %0d clears want 0", clr_addr.size() - cb); end
  endtask

  task automatic test_zero();
    int sc, wb, vb, db, eb;
    wb = words.size(); vb = vrise.size(); db = dq.size(); eb = enb_cnt;
    do_start(0, 1'b0, sc);
    wait_done(db, 10, "zero");
    checks++; if (dq.size() <= db || dq[db] - sc != 1) begin failures++; $display("FAIL zero_done_cycle: got %0d want 1", dq.size() > db ? dq[db] - sc : -1); end
    checks++; if (enb_cnt != eb) begin failures++; $display("FAIL zero_enb: got %0d enb cycles want 0", enb_cnt - eb); end
    checks++; if (vrise.size() != vb || words.size() != wb) begin failures++; $display("FAIL zero_valid: got %0d valid pulses want 0", vrise.size() - vb); end
  endtask

  task automatic test_reset_mid();
    int sc, wb, vb, db, n;
    logic hit;
    do_preload();
    m_ready = 1'b1;
    do_start(2, 1'b0, sc);
    n = 0; hit = 1'b0;
    while (!hit && n < 100) begin
      @(negedge clk); n++;
      if (m_valid && m_data === 16'h0051) hit = 1'b1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL reset_mid_reach: got no lane5/addr1 word want 0051"); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({m_valid, busy, done} !== 3'b000) begin failures++; $display("FAIL reset_mid_flags: got %b want 000", {m_valid, busy, done}); end
    checks++; if ((enb | ena_clear | wea_clear) !== '0 || m_data !== '0) begin failures++; $display("FAIL reset_mid_outputs: got enb=%h m_data=%h want 0", enb, m_data); end
    rst = 1'b1;
    wb = words.size(); vb = vrise.size(); db = dq.size();
    do_start(1, 1'b0, sc);
    wait_done(db, 100, "reset_mid");
    checks++; if (words.size() - wb != 16) begin failures++; $display("FAIL reset_mid_count: got %0d want 16", words.size() - wb); end
    checks++; if (words.size() < wb + 16 || words[wb] !== 16'h0000 || words[wb+15] !== 16'h00F0) begin failures++; $display("FAIL reset_mid_restart: first/last word wrong, want 0000/00F0"); end
    checks++; if (vrise.size() <= vb || vrise[vb] - sc != 4) begin failures++; $display("FAIL reset_mid_latency: got %0d want 4", vrise.size() > vb ? vrise[vb] - sc : -1); end
  endtask

  task automatic test_start_busy();
    int sc, wb, db;
    m_ready = 1'b1;
    wb = words.size(); db = dq.size();
    do_start(1, 1'b0, sc);
    repeat (6) @(posedge clk);
    #1; start = 1'b1; num_words = 5'd2;
    @(posedge clk); #1; start = 1'b0;
    wait_done(db, 100, "start_busy");
    repeat (10) @(posedge clk);
    #1;
    checks++; if (words.size() - wb != 16) begin failures++; $display("FAIL start_busy_count: got %0d want 16", words.size() - wb); end
    checks++; if (dq.size() - db != 1) begin failures++; $display("FAIL start_busy_dones: got %0d want 1", dq.size() - db); end
    checks++; if (dq.size() <= db || dq[db] - sc != 21) begin failures++; $display("FAIL start_busy_done_cycle: got %0d want 21", dq.size() > db ? dq[db] - sc : -1); end
  endtask

  initial begin
    test_reset();
    test_drain_two();
    test_toggle();
    test_clear();
    test_zero();
    test_reset_mid();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
